lcd_video_rx: RTL and testbench

LCD_VIDEO_RX -- requirements
Module: lcd_video_rx

---
 rtl/lcd_video_pkg.sv | 23 ++
 rtl/lcd_crc16.sv | 33 +++
 rtl/lcd_video_rx.sv | 206 ++++++++++++++++++++
 tb/tb_lcd_video_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_video_pkg.sv
// Shared types and widths for the LCD video receiver.
package lcd_video_pkg;

  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned PIX_W = 16;
  localparam int unsigned CNT_W = 4;

  // Lock tracking states
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // RGB565 pixel as it arrives on LCD_DATA
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/lcd_crc16.sv
// CRC-16-CCITT (poly 0x1021), one 16-bit word per enabled cycle, MSB first.
module lcd_crc16 (
  input  logic        clk_pix,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] crc
);

  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // Running CRC; init has priority so a new frame always starts from 0xFFFF
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      crc <= 16'hFFFF;
    end else if (init) begin
      crc <= 16'hFFFF;
    end else if (en) begin
      crc <= crc_word(crc, data);
    end
  end

endmodule

// File: rtl/lcd_video_rx.sv
// LCD parallel RGB565 receiver: measures line/frame timing, locks to
// H_ACT x V_ACT and emits pixels with coordinates while locked.
// Optional per-frame CRC output enabled by defining LCD_VIDEO_RX_CRC_EN.
module lcd_video_rx
  import lcd_video_pkg::*;
#(
  parameter int unsigned H_ACT       = 800,
  parameter int unsigned V_ACT       = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             clk_pix,
  input  logic             reset,
  input  logic             LCD_HSYNC,
  input  logic             LCD_VSYNC,
  input  logic             LCD_DEN,
  input  logic [PIX_W-1:0] LCD_DATA,
  output logic [PIX_W-1:0] pix_data,
  output logic [X_W-1:0]   pix_x,
  output logic [Y_W-1:0]   pix_y,
  output logic             pix_valid,
  output logic             frame_start,
  output logic             locked,
  output logic [X_W-1:0]   h_meas,
  output logic [Y_W-1:0]   v_meas,
  output logic             err
`ifdef LCD_VIDEO_RX_CRC_EN
  ,
  output logic [15:0]      frame_crc,
  output logic             crc_valid
`endif
);

  logic                 r_hs, r_vs, d_vs, r_den;
  rgb565_t              r_data;
  logic [X_W-1:0]       x_cnt;
  logic [Y_W-1:0]       line_cnt;
  logic                 frame_ok;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     good_cnt, good_d;
  logic                 err_d;

  logic                 den_fall_c, vs_fall_c, run_bad_c, line_over_c;
  logic                 den_in_vs_c, frame_good_c;
  logic [X_W-1:0]       x_inc_c;
  logic [Y_W-1:0]       line_inc_c, lines_end_c;
  logic                 unused_hs;

  // HSYNC is registered with the other inputs but plays no part in counting
  assign unused_hs = r_hs;

  // Single input register stage; sync lines reset to their idle (high) level
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      r_hs   <= 1'b1;
      r_vs   <= 1'b1;
      d_vs   <= 1'b1;
      r_den  <= 1'b0;
      r_data <= '0;
    end else begin
      r_hs   <= LCD_HSYNC;
      r_vs   <= LCD_VSYNC;
      d_vs   <= r_vs;
      r_den  <= LCD_DEN;
      r_data <= rgb565_t'(LCD_DATA);
    end
  end

  // Edge detection and frame judgement; every run is at least one pixel long,
  // so a nonzero x count with DEN low marks the end of a run
  always_comb begin
    x_inc_c      = (x_cnt == '1) ? x_cnt : x_cnt + X_W'(1);
    line_inc_c   = (line_cnt == '1) ? line_cnt : line_cnt + Y_W'(1);
    den_fall_c   = ~r_den & (x_cnt != '0);
    vs_fall_c    = d_vs & ~r_vs;
    den_in_vs_c  = r_den & ~r_vs;
    run_bad_c    = den_fall_c & (x_cnt != X_W'(H_ACT));
    line_over_c  = den_fall_c & (line_cnt >= Y_W'(V_ACT));
    lines_end_c  = den_fall_c ? line_inc_c : line_cnt;
    frame_good_c = frame_ok & ~run_bad_c & (lines_end_c == Y_W'(V_ACT));
  end

  // Pixel/line counters and timing measurements
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      x_cnt    <= '0;
      line_cnt <= '0;
      h_meas   <= '0;
      v_meas   <= '0;
      frame_ok <= 1'b0;
    end else begin
      x_cnt <= r_den ? x_inc_c : '0;
      if (den_fall_c) begin
        h_meas <= x_cnt;
      end
      if (vs_fall_c) begin
        v_meas   <= lines_end_c;
        line_cnt <= '0;
        frame_ok <= ~den_in_vs_c;
      end else begin
        if (den_fall_c) begin
          line_cnt <= line_inc_c;
        end
        if (run_bad_c | den_in_vs_c) begin
          frame_ok <= 1'b0;
        end
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      state_q  <= ST_UNLOCKED;
      good_cnt <= '0;
    end else begin
      state_q  <= state_d;
      good_cnt <= good_d;
    end
  end

  // Lock FSM next state: first edge after reset only starts acquisition
  always_comb begin
    state_d = state_q;
    good_d  = good_cnt;
    err_d   = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (vs_fall_c) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (vs_fall_c) begin
          if (frame_good_c) begin
            good_d = good_cnt + CNT_W'(1);
            if (good_cnt + CNT_W'(1) == CNT_W'(LOCK_FRAMES)) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (run_bad_c | line_over_c | (vs_fall_c & ~frame_good_c)) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        good_d  = '0;
      end
    endcase
  end

  // Output register stage: pixels land two edges after the input sample
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
    end else begin
      pix_data    <= r_data;
      pix_x       <= x_cnt;
      pix_y       <= line_cnt;
      pix_valid   <= r_den & (state_q == ST_LOCKED);
      frame_start <= r_den & (state_q == ST_LOCKED) & (x_cnt == '0) & (line_cnt == '0);
      locked      <= (state_d == ST_LOCKED);
      err         <= err_d;
    end
  end

`ifdef LCD_VIDEO_RX_CRC_EN
  logic [15:0] crc_q;

  lcd_crc16 u_crc (
    .clk_pix (clk_pix),
    .reset   (reset),
    .init    (vs_fall_c),
    .en      (pix_valid),
    .data    (pix_data),
    .crc     (crc_q)
  );

  // Publish the accumulated CRC at the frame edge that closes a locked frame
  always_ff @(posedge clk_pix) begin
    if (reset) begin
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= vs_fall_c & (state_q == ST_LOCKED);
      if (vs_fall_c & (state_q == ST_LOCKED)) begin
        frame_crc <= crc_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lcd_video_rx.sv
// Directed bench for lcd_video_rx using a scaled 16x6 frame format.
module tb_lcd_video_rx;

  localparam int unsigned H   = 16;
  localparam int unsigned V   = 6;
  localparam int unsigned LF  = 2;
  localparam int unsigned HBL = 5;

  logic        clk_pix = 1'b0;
  logic        reset;
  logic        LCD_HSYNC, LCD_VSYNC, LCD_DEN;
  logic [15:0] LCD_DATA;
  logic [15:0] pix_data;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        pix_valid, frame_start, locked, err;
  logic [10:0] h_meas;
  logic [9:0]  v_meas;
`ifdef LCD_VIDEO_RX_CRC_EN
  logic [15:0] frame_crc;
  logic        crc_valid;
  logic [15:0] crc_model;
  logic        crc_chk = 1'b0;
`endif

  int   n_checks  = 0;
  int   n_errors  = 0;
  logic zero_data = 1'b0;

  lcd_video_rx #(.H_ACT(H), .V_ACT(V), .LOCK_FRAMES(LF)) dut (
    .clk_pix     (clk_pix),
    .reset       (reset),
    .LCD_HSYNC   (LCD_HSYNC),
    .LCD_VSYNC   (LCD_VSYNC),
    .LCD_DEN     (LCD_DEN),
    .LCD_DATA    (LCD_DATA),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .locked      (locked),
    .h_meas      (h_meas),
    .v_meas      (v_meas),
    .err         (err)
`ifdef LCD_VIDEO_RX_CRC_EN
    ,
    .frame_crc   (frame_crc),
    .crc_valid   (crc_valid)
`endif
  );

  always #5 clk_pix = ~clk_pix;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are also observed there
  task automatic drive(input logic vs, input logic hs, input logic den, input logic [15:0] d);
    @(negedge clk_pix);
    LCD_VSYNC = vs;
    LCD_HSYNC = hs;
    LCD_DEN   = den;
    LCD_DATA  = d;
  endtask

  function automatic logic [15:0] pix_val(input int l, input int i);
    return zero_data ? 16'h0000 : 16'((l << 8) + i + 1);
  endfunction

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    r = c;
    for (int b = 15; b >= 0; b--) begin
      if (r[15] ^ d[b]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // mode 1: first pixel of a locked frame; mode 2: run that must raise err;
  // mode 4: first line while not locked. After drive i, outputs show pixel i-2.
  task automatic send_line(input int l, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, (i < 2) ? 1'b0 : 1'b1, 1'b1, pix_val(l, i));
      if (mode == 1 && i == 1) check("latency_pre_valid", 32'(pix_valid), 32'(0));
      if (mode == 1 && i == 2) begin
        check("frame_start", 32'(frame_start), 32'(1));
        check("first_pix_x", 32'(pix_x), 32'(0));
        check("first_pix_y", 32'(pix_y), 32'(0));
        check("first_valid", 32'(pix_valid), 32'(1));
        check("first_data", 32'(pix_data), 32'h0001);
      end
      if (mode == 1 && i == 3) begin
        check("frame_start_pulse", 32'(frame_start), 32'(0));
        check("second_pix_x", 32'(pix_x), 32'(1));
      end
      if (mode == 4 && i == 2) check("unlocked_no_valid", 32'(pix_valid), 32'(0));
    end
    for (int j = 0; j < int'(HBL); j++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0000);
      if (mode == 2 && j == 1) check("err_early", 32'(err), 32'(0));
      if (mode == 2 && j == 2) begin
        check("err_pulse", 32'(err), 32'(1));
        check("err_unlock", 32'(locked), 32'(0));
        check("err_h_meas", 32'(h_meas), 32'(n));
      end
      if (mode == 2 && j == 3) check("err_single", 32'(err), 32'(0));
    end
  endtask

  task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                            input int first_mode);
    for (int l = 0; l < nlines; l++) begin
      if (l == bad_line)  send_line(l, bad_len, 2);
      else if (l == 0)    send_line(l, int'(H), first_mode);
      else                send_line(l, int'(H), 0);
    end
  endtask

  // Sync pulse closing one frame; negative expectations are skipped
  task automatic vsync(input int lock_pre, input int lock_post, input int vm,
                       input int err_post, input logic glitch);
    for (int c = 0; c < 6; c++) begin
      drive((c < 3) ? 1'b0 : 1'b1, 1'b1, glitch && (c == 1), 16'h0000);
      if (c == 1 && lock_pre >= 0) check("lock_before_edge", 32'(locked), 32'(lock_pre));
      if (c == 2) begin
        if (lock_post >= 0) check("lock_after_edge", 32'(locked), 32'(lock_post));
        if (vm >= 0)        check("v_meas", 32'(v_meas), 32'(vm));
        if (err_post >= 0)  check("edge_err", 32'(err), 32'(err_post));
      end
`ifdef LCD_VIDEO_RX_CRC_EN
      if (crc_chk && c == 1) check("crc_valid_pre", 32'(crc_valid), 32'(0));
      if (crc_chk && c == 2) begin
        check("crc_valid", 32'(crc_valid), 32'(1));
        check("frame_crc", 32'(frame_crc), 32'(crc_model));
      end
      if (crc_chk && c == 3) check("crc_valid_single", 32'(crc_valid), 32'(0));
`endif
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_data"}, 32'(pix_data), 32'(0));
    check({tag, "_pix_x"}, 32'(pix_x), 32'(0));
    check({tag, "_pix_y"}, 32'(pix_y), 32'(0));
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'(0));
    check({tag, "_frame_start"}, 32'(frame_start), 32'(0));
    check({tag, "_locked"}, 32'(locked), 32'(0));
    check({tag, "_h_meas"}, 32'(h_meas), 32'(0));
    check({tag, "_v_meas"}, 32'(v_meas), 32'(0));
    check({tag, "_err"}, 32'(err), 32'(0));
  endtask

  initial begin
    reset     = 1'b1;
    LCD_HSYNC = 1'b1;
    LCD_VSYNC = 1'b1;
    LCD_DEN   = 1'b0;
    LCD_DATA  = 16'h0000;
    repeat (3) drive(1'b1, 1'b1, 1'b0, 16'h0000);
    check_all_zero("reset");
    reset = 1'b0;

    // Partial frame before the first edge is only counted, never judged
    send_frame(3, -1, 0, 0);
    vsync(0, 0, 3, 0, 1'b0);
    send_frame(int'(V), -1, 0, 4);
    vsync(0, 0, 6, 0, 1'b0);
    send_frame(int'(V), -1, 0, 0);
    vsync(0, 1, 6, 0, 1'b0);

    // First locked frame: frame_start on pixel (0,0)
    send_frame(int'(V), -1, 0, 1);
    check("h_meas_full", 32'(h_meas), 32'(H));
    vsync(1, 1, 6, 0, 1'b0);

    // Short line drops lock immediately; two good frames relock
    send_frame(int'(V), 2, int'(H) - 1, 0);
    vsync(0, 0, 6, 0, 1'b0);
    send_frame(int'(V), -1, 0, 0);
    vsync(0, 0, 6, 0, 1'b0);
    send_frame(int'(V), -1, 0, 0);
    vsync(0, 1, 6, 0, 1'b0);

    // Extra line: error when the run past V_ACT ends
    send_frame(int'(V) + 1, int'(V), int'(H), 0);
    vsync(0, 0, 7, 0, 1'b0);

    // DEN glitch inside the sync pulse spoils the following frame
    send_frame(int'(V), -1, 0, 0);
    vsync(0, 0, 6, 0, 1'b1);
    send_frame(int'(V), -1, 0, 0);
    vsync(0, 0, 7, 0, 1'b0);
    send_frame(int'(V), -1, 0, 0);
    vsync(0, 0, 6, 0, 1'b0);
    send_frame(int'(V), -1, 0, 0);
    vsync(0, 1, 6, 0, 1'b0);

    // Reset in the middle of a locked line
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, (i < 2) ? 1'b0 : 1'b1, 1'b1, pix_val(0, i));
      if (i == 8) begin
        check("pre_reset_valid", 32'(pix_valid), 32'(1));
        check("pre_reset_x", 32'(pix_x), 32'(6));
        reset = 1'b1;
      end
    end
    drive(1'b1, 1'b1, 1'b1, pix_val(0, 9));
    check_all_zero("midreset");
    reset = 1'b0;
    for (int i = 10; i < int'(H); i++) begin
      drive(1'b1, 1'b1, 1'b1, pix_val(0, i));
      if (i == 10) check("post_reset_err", 32'(err), 32'(0));
    end
    for (int j = 0; j < int'(HBL); j++) drive(1'b1, 1'b1, 1'b0, 16'h0000);
    send_line(1, int'(H), 0);
    send_line(2, int'(H), 0);
    vsync(0, 0, 3, 0, 1'b0);
    send_frame(int'(V), -1, 0, 0);
    vsync(0, 0, 6, 0, 1'b0);
    send_frame(int'(V), -1, 0, 0);
    vsync(0, 1, 6, 0, 1'b0);

    // Locked frame of constant zero pixels
    zero_data = 1'b1;
`ifdef LCD_VIDEO_RX_CRC_EN
    crc_model = 16'hFFFF;
    for (int k = 0; k < int'(H * V); k++) crc_model = crc_step(crc_model, 16'h0000);
    crc_chk = 1'b1;
`endif
    send_frame(int'(V), -1, 0, 0);
    vsync(1, 1, 6, 0, 1'b0);
    check("final_locked", 32'(locked), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
